// File: rtl/iddmm_pkg.sv
// Shared IDDMM types and the multiplier latency default, so the loop sequencer and
// iddmm_mul_128_to_128 always agree on pipeline depth.
package iddmm_pkg;
  localparam int MUL_LAT_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_Q0,
    S_WQ0,
    S_Q1,
    S_WQ1,
    S_ROW,
    S_DRAIN
  } state_e;
endpackage

// File: rtl/iddmm_ctrl_delay.sv
// Fixed-depth shift line with synchronous flush; realigns control to a pipelined datapath.
module iddmm_ctrl_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (flush) begin
      sh_d = '0;
    end else begin
      sh_d[0] = din;
      for (int s = 1; s < DEPTH; s++) sh_d[s] = sh_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= sh_d;
  end

  assign dout = sh_q[DEPTH-1];
endmodule

// File: rtl/iddmm_loop_ctrl.sv
// IDDMM loop sequencer: per outer word i, issues the two q-update multiplies, sweeps
// j = 0..N across the row, then drains the accumulator writeback before the next row.
module iddmm_loop_ctrl
  import iddmm_pkg::*;
#(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int ADDR_W  = $clog2(N),
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] i_cnt,
  output logic [ADDR_W:0]   j_cnt,
  output logic              q_issue,
  output logic              q_sel,
  output logic              q_capture,
  output logic              row_en,
  output logic              a_wr_en,
  output logic [ADDR_W:0]   a_wr_addr
);
  localparam int WAIT_W = $clog2(MUL_LAT) + 1;

  if (K < 1 || N < 2 || MUL_LAT < 2) begin : g_bad_param
    $error("iddmm_loop_ctrl: need K >= 1, N >= 2, MUL_LAT >= 2");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   i_q, i_d;
  logic [ADDR_W:0]     j_q, j_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                done_q, done_d;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_Q0;
      S_Q0: begin
        state_d = S_WQ0;
        wait_d  = WAIT_W'(MUL_LAT - 2);
      end
      S_WQ0:
        if (wait_q == '0) state_d = S_Q1;
        else              wait_d  = wait_q - 1'b1;
      S_Q1: begin
        state_d = S_WQ1;
        wait_d  = WAIT_W'(MUL_LAT - 2);
      end
      S_WQ1:
        if (wait_q == '0) begin
          state_d = S_ROW;
          j_d     = '0;
        end else begin
          wait_d  = wait_q - 1'b1;
        end
      S_ROW:
        // j runs one past N-1 to cover the carry word
        if (j_q == (ADDR_W+1)'(N)) begin
          state_d = S_DRAIN;
          j_d     = '0;
          wait_d  = WAIT_W'(MUL_LAT - 1);
        end else begin
          j_d     = j_q + 1'b1;
        end
      S_DRAIN:
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else if (i_q == ADDR_W'(N - 1)) begin
          state_d = S_IDLE;
          i_d     = '0;
          done_d  = 1'b1;
        end else begin
          state_d = S_Q0;
          i_d     = i_q + 1'b1;
        end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      i_d     = '0;
      j_d     = '0;
      wait_d  = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign i_cnt     = i_q;
  assign j_cnt     = j_q;
  assign q_issue   = (state_q == S_Q0) || (state_q == S_Q1);
  assign q_sel     = (state_q == S_Q1) || (state_q == S_WQ1);
  // final q emerges MUL_LAT cycles after the Q1 issue, i.e. on the first ROW cycle
  assign q_capture = (state_q == S_ROW) && (j_q == '0);
  assign row_en    = (state_q == S_ROW);

  iddmm_ctrl_delay #(
    .WIDTH (ADDR_W + 2),
    .DEPTH (MUL_LAT)
  ) u_wr_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .din   ({row_en, j_q}),
    .dout  ({a_wr_en, a_wr_addr})
  );
endmodule

// File: tb/tb_iddmm_loop_ctrl.sv
// Directed bench for iddmm_loop_ctrl at N=4, MUL_LAT=4 (row length 17, run length 68).
module tb_iddmm_loop_ctrl;
  localparam int N  = 4;
  localparam int ML = 4;
  localparam int AW = 2;
  localparam int R  = 3*ML + N + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, q_issue, q_sel, q_capture, row_en, a_wr_en;
  logic [AW-1:0] i_cnt;
  logic [AW:0]   j_cnt, a_wr_addr;

  int n_cmp = 0;
  int n_bad = 0;

  typedef logic [14:0] ov_t;

  iddmm_loop_ctrl #(.K(128), .N(N), .ADDR_W(AW), .MUL_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .i_cnt(i_cnt), .j_cnt(j_cnt),
    .q_issue(q_issue), .q_sel(q_sel), .q_capture(q_capture),
    .row_en(row_en), .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr)
  );

  always #5 clk = ~clk;

  function automatic ov_t obs();
    return {busy, done, q_issue, q_sel, q_capture, row_en, a_wr_en, i_cnt, j_cnt, a_wr_addr};
  endfunction

  // Expected outputs at cycle offset m (0..N*R-1) after start accept, from the row timeline:
  // Q0@0, Q1@4, capture@8, ROW@8..12, writes@12..16.
  function automatic ov_t exp_run(int m);
    int o;
    logic [AW-1:0] ei;
    logic [AW:0]   ej, ea;
    logic          iss, sel, cap, ren, wen;
    o   = m % R;
    ei  = AW'(m / R);
    iss = (o == 0) || (o == 4);
    sel = (o >= 4) && (o <= 7);
    cap = (o == 8);
    ren = (o >= 8) && (o <= 12);
    wen = (o >= 12) && (o <= 16);
    ej  = ren ? 3'(o - 8)  : 3'd0;
    ea  = wen ? 3'(o - 12) : 3'd0;
    return {1'b1, 1'b0, iss, sel, cap, ren, wen, ei, ej, ea};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (obs() !== '0) begin n_bad++; $display("FAIL reset_async got %h want 0", obs()); end
    step();
    n_cmp++;
    if (obs() !== '0) begin n_bad++; $display("FAIL reset_held got %h want 0", obs()); end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs() !== '0) begin n_bad++; $display("FAIL reset_idle got %h want 0", obs()); end
  endtask

  task automatic test_full_run();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int m = 0; m < N*R; m++) begin
      n_cmp++;
      if (obs() !== exp_run(m)) begin
        n_bad++;
        $display("FAIL full_run off=%0d got %h want %h", m, obs(), exp_run(m));
      end
      step();
    end
    n_cmp++;
    if (obs() !== {2'b01, 13'b0}) begin n_bad++; $display("FAIL done_pulse got %h want %h", obs(), {2'b01, 13'b0}); end
    step();
    n_cmp++;
    if (obs() !== '0) begin n_bad++; $display("FAIL after_done got %h want 0", obs()); end
  endtask

  task automatic test_abort();
    int busy_cyc, done_at;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int m = 1; m <= 2*R + 11; m++) step();
    n_cmp++;
    if (obs() !== exp_run(2*R + 11)) begin n_bad++; $display("FAIL abort_pre got %h want %h", obs(), exp_run(2*R + 11)); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (obs() !== '0) begin n_bad++; $display("FAIL abort_idle got %h want 0", obs()); end
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (obs() !== '0) begin n_bad++; $display("FAIL abort_quiet k=%0d got %h want 0", k, obs()); end
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cyc = 0;
    done_at  = -1;
    for (int k = 0; k < 200; k++) begin
      if (done) begin done_at = k; break; end
      if (busy) busy_cyc++;
      step();
    end
    n_cmp++;
    if (done_at != N*R) begin n_bad++; $display("FAIL rerun_done_at got %0d want %0d", done_at, N*R); end
    n_cmp++;
    if (busy_cyc != N*R) begin n_bad++; $display("FAIL rerun_busy got %0d want %0d", busy_cyc, N*R); end
    step();
  endtask

  task automatic test_start_held();
    start = 1'b1;
    step();
    for (int m = 1; m <= N*R; m++) begin
      step();
      if (m == R) begin
        n_cmp++;
        if (obs() !== exp_run(R)) begin n_bad++; $display("FAIL held_row1 got %h want %h", obs(), exp_run(R)); end
      end
    end
    n_cmp++;
    if ({busy, done} !== 2'b01) begin n_bad++; $display("FAIL held_done got %b want 01", {busy, done}); end
    step();
    n_cmp++;
    if ({busy, done, q_issue, i_cnt} !== {3'b101, 2'd0}) begin
      n_bad++; $display("FAIL held_restart got %b want 10100", {busy, done, q_issue, i_cnt});
    end
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (obs() !== '0) begin n_bad++; $display("FAIL held_abort got %h want 0", obs()); end
    start = 1'b1;
    abort = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL start_abort1 got %b want 0", busy); end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL start_abort2 got %b want 0", busy); end
    start = 1'b0;
    abort = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int m = 1; m <= R + 6; m++) step();
    n_cmp++;
    if (obs() !== exp_run(R + 6)) begin n_bad++; $display("FAIL mid_pre got %h want %h", obs(), exp_run(R + 6)); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== '0) begin n_bad++; $display("FAIL mid_async got %h want 0", obs()); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (obs() !== '0) begin n_bad++; $display("FAIL mid_after k=%0d got %h want 0", k, obs()); end
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_abort();
    test_start_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
